issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Dual-issue front-end buffer between instruction fetch and the dual-issue decode stage.
- Accepts up to two fetched instructions per cycle into a circular queue.
- Each cycle it selects 0, 1 or 2 in-order instructions from the head, subject to pairing rules, and presents them as registered instruction1/instruction2 slots to decode.
- Acts as the IF/ID pipeline register for both issue slots.

Parameters:
- DEPTH, 8, queue entries (power of two, >= 4).
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid1  in  1  in_instr1 carries a valid fetched word.
- in_valid2  in  1  in_instr2 valid; only honoured when in_valid1=1.
- in_pc  in  32  PC of in_instr1; in_instr2 is at in_pc+4.
- in_instr1  in  32  older fetched instruction.
- in_instr2  in  32  younger fetched instruction.
- in_ready  out  1  queue can accept two words this cycle.
- stall  in  1  hold output slots and queue head (from hazard unit).
- flush  in  1  discard queue and output slots (taken branch/jump).
- instruction1  out  32  slot-1 instruction to decode (older).
- instruction2  out  32  slot-2 instruction to decode (younger).
- pc1  out  32  PC of instruction1.
- pc2  out  32  PC of instruction2.
- valid1  out  1  slot 1 holds a real instruction.
- valid2  out  1  slot 2 holds a real instruction; never 1 while valid1=0.
- count  out  PTR_W+1  current queue occupancy.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}.
  - head/tail pointers are PTR_W bits and wrap modulo DEPTH.
  - occupancy counter ranges 0..DEPTH.
- in_ready = (count <= DEPTH-2), computed from the registered count before this cycle's pop. This is conservative by design.
- Push, when in_valid1 && in_ready:
  - Write entry tail = {in_pc, in_instr1}.
  - If in_valid2, also write entry tail+1 = {in_pc+4, in_instr2}.
  - tail advances by 1 or 2. Pushes while !in_ready are dropped; fetch must hold.
- Issue selection (combinational, from the head entries H0/H1):
  - n=0 if count=0.
  - n=1 if count=1, or if the pair fails the pairing check.
  - n=2 otherwise.
- Pairing check (slot 2 is blocked if any rule holds):
  - H0 is a control transfer: beq 0x04, bne 0x05, j 0x02, jal 0x03, or R-type funct 0x08 (jr).
  - H0 and H1 are both memory ops (lw 0x23, sw 0x2B).
  - RAW: H0 writes a nonzero register D, and H1 reads D.
  - WAW: both write the same nonzero register.
- Register writes (destination D):
  - R-type except jr writes rd.
  - I-type ALU ops and lw write rt.
  - jal writes 31.
  - sw, beq, bne, j and jr write nothing.
- Register reads:
  - R-type reads rs and rt.
  - sw, beq and bne read rs and rt.
  - Other I-type ops read rs.
  - j and jal read nothing.
- Clock edge, when !stall && !flush:
  - Output slots load the n selected entries.
  - An unfilled slot loads instruction=32'h0, pc=32'h0, valid=0.
  - head advances by n.
- Clock edge, when stall && !flush:
  - Output slots and head hold.
  - Push still proceeds.
- Simultaneous push and pop in one edge: count_next = count + pushed - n.
  - Wrap across DEPTH-1 -> 0 is transparent.
- flush (priority over stall and push):
  - head = tail = count = 0.
  - Both slots load NOP with valid=0.
  - Same-cycle push is discarded.
- Reset (rst=0 at an edge):
  - Same effect as flush.
  - in_ready=1 after reset.
  - All outputs are 0 except in_ready.
  - Reset mid-stall clears everything.
- Latency: a word pushed at edge N appears in an output slot at edge N+1 at the earliest (queue empty, no stall).

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL) and FUNCT_JR;
  - NOP word 32'h0.
- Sub-module pair_check, purely combinational:
  - inputs: two 32-bit instructions;
  - outputs: can_pair, plus per-instruction writes_reg/dest/reads_rs/reads_rt.
  - Verified standalone.

Test Plan:
- Reset: rst=0 for 2 cycles -> valid1=valid2=0, count=0, in_ready=1, instruction1=0.
- Independent pair: push add $3,$1,$2 / sub $6,$4,$5 at pc 0x100 -> next edge valid1=valid2=1, pc1=0x100, pc2=0x104, count=0.
- RAW split: push add $3,$1,$2 / addi $7,$3,1 -> first edge only the add issues (valid2=0), next edge addi issues in slot 1 with pc1=0x104.
- Structural and control: push lw / sw pair -> issued singly on consecutive edges. Push beq / add -> beq issues alone.
- Full/wrap: hold stall=1 and push 4 pairs into DEPTH=8 -> count=8, in_ready=0, a 5th push is dropped. Release stall -> 8 entries drain in order with correct PCs across the pointer wrap.
- Flush: with count=5 and a simultaneous push, assert flush -> next edge count=0, valid1=valid2=0. The pushed words never appear at the outputs.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared opcode constants, queue entry type and the instruction decode helper
// used by the issue queue and its pairing checker.
package issue_queue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [31:0] NOP    = 32'h0;
    localparam logic [4:0]  REG_RA = 5'd31;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct packed {
        logic       writes_reg;
        logic [4:0] dest;
        logic       reads_rs;
        logic       reads_rt;
        logic       is_ctrl;
        logic       is_mem;
    } decode_t;

    // Anything not explicitly listed is treated as an I-type ALU op (reads rs, writes rt).
    function automatic decode_t decode(input logic [31:0] instr);
        decode_t d;
        d = '0;
        case (instr[31:26])
            OP_RTYPE: begin
                d.reads_rs = 1'b1;
                d.reads_rt = 1'b1;
                if (instr[5:0] == FUNCT_JR) begin
                    d.is_ctrl = 1'b1;
                end else begin
                    d.writes_reg = 1'b1;
                    d.dest       = instr[15:11];
                end
            end
            OP_J: d.is_ctrl = 1'b1;
            OP_JAL: begin
                d.is_ctrl    = 1'b1;
                d.writes_reg = 1'b1;
                d.dest       = REG_RA;
            end
            OP_BEQ, OP_BNE: begin
                d.is_ctrl  = 1'b1;
                d.reads_rs = 1'b1;
                d.reads_rt = 1'b1;
            end
            OP_SW: begin
                d.is_mem   = 1'b1;
                d.reads_rs = 1'b1;
                d.reads_rt = 1'b1;
            end
            OP_LW: begin
                d.is_mem     = 1'b1;
                d.reads_rs   = 1'b1;
                d.writes_reg = 1'b1;
                d.dest       = instr[20:16];
            end
            default: begin
                d.reads_rs   = 1'b1;
                d.writes_reg = 1'b1;
                d.dest       = instr[20:16];
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_queue_pair_check.sv
// Decides whether the two oldest queued instructions may issue together
// (no control transfer in slot 1, no double memory op, no RAW/WAW on a nonzero reg).
module issue_queue_pair_check
    import issue_queue_pkg::*;
(
    input  logic [31:0] instr1,
    input  logic [31:0] instr2,
    output logic        can_pair,
    output logic        writes_reg1,
    output logic [4:0]  dest1,
    output logic        reads_rs1,
    output logic        reads_rt1,
    output logic        writes_reg2,
    output logic [4:0]  dest2,
    output logic        reads_rs2,
    output logic        reads_rt2
);

    logic [31:0] instr_arr [2];
    decode_t     dec [2];
    logic        raw;
    logic        waw;

    assign instr_arr[0] = instr1;
    assign instr_arr[1] = instr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            assign dec[gi] = decode(instr_arr[gi]);
        end
    endgenerate

    assign raw = dec[0].writes_reg && (dec[0].dest != 5'd0) &&
                 ((dec[1].reads_rs && (instr2[25:21] == dec[0].dest)) ||
                  (dec[1].reads_rt && (instr2[20:16] == dec[0].dest)));

    assign waw = dec[0].writes_reg && dec[1].writes_reg &&
                 (dec[0].dest != 5'd0) && (dec[0].dest == dec[1].dest);

    assign can_pair = !(dec[0].is_ctrl || (dec[0].is_mem && dec[1].is_mem) || raw || waw);

    assign writes_reg1 = dec[0].writes_reg;
    assign dest1       = dec[0].dest;
    assign reads_rs1   = dec[0].reads_rs;
    assign reads_rt1   = dec[0].reads_rt;
    assign writes_reg2 = dec[1].writes_reg;
    assign dest2       = dec[1].dest;
    assign reads_rs2   = dec[1].reads_rs;
    assign reads_rt2   = dec[1].reads_rt;

endmodule

// File: rtl/issue_queue.sv
// Dual-issue fetch buffer: circular queue of {pc, instr} feeding two registered
// decode slots, doubling as the IF/ID pipeline register.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid1,
    input  logic             in_valid2,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr1,
    input  logic [31:0]      in_instr2,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      instruction1,
    output logic [31:0]      instruction2,
    output logic [31:0]      pc1,
    output logic [31:0]      pc2,
    output logic             valid1,
    output logic             valid2,
    output logic [PTR_W:0]   count
);

    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_reg [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    entry_t             slot1_reg;
    entry_t             slot2_reg;
    logic               valid1_reg;
    logic               valid2_reg;

    entry_t             h0;
    entry_t             h1;
    logic               can_pair;
    logic               push_en;
    logic [CNT_W-1:0]   push_cnt;
    logic [CNT_W-1:0]   issue_n;
    logic [CNT_W-1:0]   pop_n;

    logic               wr1, wr2, rs1, rs2, rt1, rt2;
    logic [4:0]         d1, d2;
    logic [11:0]        pair_unused;

    assign h0 = mem_reg[head_reg];
    assign h1 = mem_reg[head_reg + PTR_W'(1)];

    issue_queue_pair_check u_pair_check (
        .instr1      (h0.instr),
        .instr2      (h1.instr),
        .can_pair    (can_pair),
        .writes_reg1 (wr1),
        .dest1       (d1),
        .reads_rs1   (rs1),
        .reads_rt1   (rt1),
        .writes_reg2 (wr2),
        .dest2       (d2),
        .reads_rs2   (rs2),
        .reads_rt2   (rt2)
    );
    assign pair_unused = {wr1, rs1, rt1, wr2, rs2, rt2, d1[2:0], d2[2:0]};

    // Judged on the pre-pop count, so a full queue refuses even if it drains this cycle.
    assign in_ready = (count_reg <= CNT_W'(DEPTH - 2));
    assign push_en  = in_valid1 && in_ready;

    always_comb begin
        push_cnt = '0;
        issue_n  = '0;
        if (push_en) begin
            push_cnt = in_valid2 ? CNT_W'(2) : CNT_W'(1);
        end
        if (count_reg == CNT_W'(0)) begin
            issue_n = '0;
        end else if ((count_reg == CNT_W'(1)) || !can_pair) begin
            issue_n = CNT_W'(1);
        end else begin
            issue_n = CNT_W'(2);
        end
        pop_n      = stall ? '0 : issue_n;
        count_next = count_reg + push_cnt - pop_n;
    end

    always_ff @(posedge clk) begin
        if (push_en && rst && !flush) begin
            mem_reg[tail_reg] <= '{pc: in_pc, instr: in_instr1};
            if (in_valid2) begin
                mem_reg[tail_reg + PTR_W'(1)] <= '{pc: in_pc + 32'd4, instr: in_instr2};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            slot1_reg  <= '{pc: 32'h0, instr: NOP};
            slot2_reg  <= '{pc: 32'h0, instr: NOP};
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
        end else begin
            tail_reg  <= tail_reg + push_cnt[PTR_W-1:0];
            head_reg  <= head_reg + pop_n[PTR_W-1:0];
            count_reg <= count_next;
            if (!stall) begin
                slot1_reg  <= (issue_n != '0) ? h0 : '{pc: 32'h0, instr: NOP};
                slot2_reg  <= (issue_n == CNT_W'(2)) ? h1 : '{pc: 32'h0, instr: NOP};
                valid1_reg <= (issue_n != '0);
                valid2_reg <= (issue_n == CNT_W'(2));
            end
        end
    end

    assign instruction1 = slot1_reg.instr;
    assign instruction2 = slot2_reg.instr;
    assign pc1          = slot1_reg.pc;
    assign pc2          = slot2_reg.pc;
    assign valid1       = valid1_reg;
    assign valid2       = valid2_reg;
    assign count        = count_reg;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: stimulus pushes expected issue groups into a
// scoreboard, a monitor pops and compares them as the DUT presents new slots.
module tb_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid1, in_valid2;
    logic [31:0] in_pc, in_instr1, in_instr2;
    logic        in_ready;
    logic        stall, flush;
    logic [31:0] instruction1, instruction2, pc1, pc2;
    logic        valid1, valid2;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc1;
        logic [31:0] i1;
        logic        v2;
        logic [31:0] pc2;
        logic [31:0] i2;
    } exp_t;
    exp_t sb[$];

    localparam logic [31:0] ADD_3_1_2  = 32'h00221820;
    localparam logic [31:0] SUB_6_4_5  = 32'h00853022;
    localparam logic [31:0] ADDI_7_3_1 = 32'h20670001;
    localparam logic [31:0] LW_8_9     = 32'h8D280000;
    localparam logic [31:0] SW_10_11   = 32'hAD6A0004;
    localparam logic [31:0] BEQ_1_2    = 32'h10220004;

    issue_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid1    (in_valid1),
        .in_valid2    (in_valid2),
        .in_pc        (in_pc),
        .in_instr1    (in_instr1),
        .in_instr2    (in_instr2),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .instruction1 (instruction1),
        .instruction2 (instruction2),
        .pc1          (pc1),
        .pc2          (pc2),
        .valid1       (valid1),
        .valid2       (valid2),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives one push cycle and returns at the following negedge.
    task automatic push(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic two);
        in_valid1 = 1'b1;
        in_valid2 = two;
        in_pc     = pc;
        in_instr1 = a;
        in_instr2 = b;
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        $display("push pc=0x%08h instr1=0x%08h instr2=0x%08h two=%0b count=%0d", pc, a, b, two, count);
    endtask

    task automatic expect_issue(input logic [31:0] p1, input logic [31:0] i1, input logic v2,
                                input logic [31:0] p2, input logic [31:0] i2);
        exp_t e;
        e.pc1 = p1; e.i1 = i1; e.v2 = v2; e.pc2 = p2; e.i2 = i2;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] addi_k(input int k);
        return 32'h20000000 | ((32'(16 + k)) << 16) | 32'(k);
    endfunction

    // Monitor: slots only change on edges with rst high and no stall/flush.
    initial begin : monitor
        logic fresh;
        exp_t e;
        forever begin
            @(posedge clk);
            fresh = rst && !stall && !flush;
            @(negedge clk);
            if (fresh && valid1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got pc1=0x%08h instr1=0x%08h expected none", pc1, instruction1);
                end else begin
                    e = sb.pop_front();
                    $display("issue pc1=0x%08h i1=0x%08h v2=%0b pc2=0x%08h i2=0x%08h", pc1, instruction1, valid2, pc2, instruction2);
                    check("pc1", pc1, e.pc1);
                    check("instruction1", instruction1, e.i1);
                    check("valid2", 32'(valid2), 32'(e.v2));
                    check("pc2", pc2, e.pc2);
                    check("instruction2", instruction2, e.i2);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        in_pc = '0; in_instr1 = '0; in_instr2 = '0;
        repeat (2) @(negedge clk);
        check("rst_valid1", 32'(valid1), 32'd0);
        check("rst_valid2", 32'(valid2), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_instruction1", instruction1, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Independent pair issues together one edge after it lands.
        expect_issue(32'h100, ADD_3_1_2, 1'b1, 32'h104, SUB_6_4_5);
        push(32'h100, ADD_3_1_2, SUB_6_4_5, 1'b1);
        check("pair_count_after_push", 32'(count), 32'd2);
        @(negedge clk);
        check("pair_count_after_issue", 32'(count), 32'd0);
        repeat (2) @(negedge clk);

        // RAW on $3 splits the pair.
        expect_issue(32'h100, ADD_3_1_2, 1'b0, 32'h0, 32'h0);
        expect_issue(32'h104, ADDI_7_3_1, 1'b0, 32'h0, 32'h0);
        push(32'h100, ADD_3_1_2, ADDI_7_3_1, 1'b1);
        @(negedge clk);
        check("raw_count_mid", 32'(count), 32'd1);
        repeat (3) @(negedge clk);

        // Two memory ops, then a branch in slot 1.
        expect_issue(32'h110, LW_8_9, 1'b0, 32'h0, 32'h0);
        expect_issue(32'h114, SW_10_11, 1'b0, 32'h0, 32'h0);
        push(32'h110, LW_8_9, SW_10_11, 1'b1);
        repeat (3) @(negedge clk);
        expect_issue(32'h120, BEQ_1_2, 1'b0, 32'h0, 32'h0);
        expect_issue(32'h124, ADD_3_1_2, 1'b0, 32'h0, 32'h0);
        push(32'h120, BEQ_1_2, ADD_3_1_2, 1'b1);
        repeat (3) @(negedge clk);

        // Single-word push moves tail off zero so the fill below wraps.
        expect_issue(32'h300, SUB_6_4_5, 1'b0, 32'h0, 32'h0);
        push(32'h300, SUB_6_4_5, ADD_3_1_2, 1'b0);
        repeat (3) @(negedge clk);
        check("single_count", 32'(count), 32'd0);

        // Fill under stall, reject a fifth push, then drain across the wrap.
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(32'h400 + 32'(8 * k), addi_k(2 * k), addi_k(2 * k + 1), 1'b1);
            if (k == 2) check("fill_ready_at_6", 32'(in_ready), 32'd1);
        end
        check("fill_count_full", 32'(count), 32'd8);
        check("fill_ready_full", 32'(in_ready), 32'd0);
        push(32'h500, ADD_3_1_2, SUB_6_4_5, 1'b1);
        check("fill_drop_count", 32'(count), 32'd8);
        for (int k = 0; k < 4; k++)
            expect_issue(32'h400 + 32'(8 * k), addi_k(2 * k), 1'b1,
                         32'h404 + 32'(8 * k), addi_k(2 * k + 1));
        stall = 1'b0;
        repeat (6) @(negedge clk);
        check("drain_count", 32'(count), 32'd0);

        // Flush beats stall and a same-cycle push.
        stall = 1'b1;
        push(32'h600, ADD_3_1_2, SUB_6_4_5, 1'b1);
        push(32'h608, LW_8_9, SW_10_11, 1'b1);
        push(32'h610, BEQ_1_2, ADD_3_1_2, 1'b0);
        check("flush_pre_count", 32'(count), 32'd5);
        flush = 1'b1;
        push(32'h700, ADD_3_1_2, SUB_6_4_5, 1'b1);
        flush = 1'b0;
        stall = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid1", 32'(valid1), 32'd0);
        check("flush_valid2", 32'(valid2), 32'd0);
        repeat (4) @(negedge clk);
        check("flush_count_later", 32'(count), 32'd0);

        // Reset while stalled with words queued.
        stall = 1'b1;
        push(32'h800, ADD_3_1_2, SUB_6_4_5, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        check("midstall_rst_count", 32'(count), 32'd0);
        check("midstall_rst_ready", 32'(in_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("midstall_rst_valid1", 32'(valid1), 32'd0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_issue: got %0d outstanding expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
